uart_rx: RTL and testbench

FSM-based UART receiver that deserialises an asynchronous serial line into bytes: 8 data bits, LSB first, optional even parity, one stop bit. It is the stage directly upstream of the UART transmitter. Its `rx_data`/`rx_valid` outputs connect straight to the transmitter's byte inputs to form the echo/loopback path. Framing and parity errors are flagged and the corrupted byte is not forwarded.

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side and serial-side signals of the UART receiver, grouped for port hookup.
// slave = receiver view; master = the driver/consumer view.
interface uart_rx_if;
  logic       rx;
  logic       parity_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;

  modport slave (
    input  rx,
    input  parity_en,
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err
  );

  modport master (
    output rx,
    output parity_en,
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 / 8E1: status pulses register at the stop-sample edge (t0+2+H+9/10 bit times).
// No back-pressure: rx_valid is a single-cycle pulse the consumer must take.
module uart_rx #(
  parameter int CLK_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]       r_idx,   w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_pen,   w_pen_nxt;
  logic             r_mis,   w_mis_nxt;
  logic [7:0]       r_data,  w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_perr,  w_perr_nxt;
  logic             r_ferr,  w_ferr_nxt;
  logic             r_sync1, r_sync2;
  logic             w_rx_s;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_pen   <= 1'b0;
      r_mis   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_pen   <= w_pen_nxt;
      r_mis   <= w_mis_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_perr  <= w_perr_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pen_nxt   = r_pen;
    w_mis_nxt   = r_mis;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt = '0;
          // A high sample at mid start bit is a glitch, not a frame.
          if (!w_rx_s) begin
            w_pen_nxt   = bus.parity_en;
            w_mis_nxt   = 1'b0;
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rx_s;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = r_pen ? S_PARITY : S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_mis_nxt   = w_rx_s ^ (^r_shift);
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt = '0;
          // Framing error wins over parity and leaves rx_data untouched.
          if (!w_rx_s) begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end else begin
            w_data_nxt  = r_shift;
            w_perr_nxt  = r_mis;
            w_valid_nxt = !r_mis;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.rx_data    = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-accurate serial driver, frame-level outcome model, pulse monitor.
module tb_uart_rx;
  localparam int C = 16;
  localparam int H = C / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus();
  uart_rx #(.CLK_PER_BIT(C)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int unsigned edge_n;
    logic [2:0]  kind;   // {valid, parity_err, frame_err}
    logic [7:0]  data;
  } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  ev_t         mon_e;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  last_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid || bus.parity_err || bus.frame_err) begin
      mon_e.edge_n = cyc;
      mon_e.kind   = {bus.rx_valid, bus.parity_err, bus.frame_err};
      mon_e.data   = bus.rx_data;
      obs_q.push_back(mon_e);
    end
  end

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic hold(input logic b);
    bus.rx = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Must be called 1 time unit after a rising edge; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stopb);
    ev_t         e;
    int unsigned t0;
    bus.parity_en = pen;
    t0 = cyc + 1;
    e.edge_n = t0 + 2 + H + (pen ? 10 : 9) * C;
    if (!stopb) begin
      e.kind = 3'b001;
    end else if (pen && (pbit != ^d)) begin
      e.kind = 3'b010;
      last_data = d;
    end else begin
      e.kind = 3'b100;
      last_data = d;
    end
    e.data = last_data;
    exp_q.push_back(e);
    hold(1'b0);
    bus.parity_en = ~pen;
    for (int i = 0; i < 8; i++) hold(d[i]);
    if (pen) hold(pbit);
    hold(stopb);
    bus.parity_en = pen;
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, " count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
      check({tag, " edge"}, obs_q[i].edge_n, exp_q[i].edge_n);
      check({tag, " data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       pen, pbit, stopb;

    bus.rx = 1'b1;
    bus.parity_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_data", 32'(bus.rx_data), 32'h00);
    check("reset rx_valid", 32'(bus.rx_valid), 32'h0);
    check("reset parity_err", 32'(bus.parity_err), 32'h0);
    check("reset frame_err", 32'(bus.frame_err), 32'h0);
    rst = 1'b0;
    idle(10);

    // 1: plain 8N1 frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(20);
    compare("t1");
    check("t1 hold", 32'(bus.rx_data), 32'hA5);

    // 2: good then bad even parity
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle(5);
    send_frame(8'h3D, 1'b1, 1'b0, 1'b1);
    idle(20);
    compare("t2");

    // 3: framing error, line held low, then released
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    bus.rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    compare("t3 ferr");
    idle(40);
    compare("t3 quiet");
    check("t3 hold", 32'(bus.rx_data), 32'h3D);

    // 4: short glitch, then a real frame
    bus.rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(30);
    compare("t4 glitch");
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle(10);
    compare("t4");

    // 5: back-to-back, zero idle gap
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    idle(10);
    compare("t5");

    // 6: reset during data bit 4
    d = 8'hC3;
    bus.parity_en = 1'b0;
    hold(1'b0);
    for (int i = 0; i < 4; i++) hold(d[i]);
    bus.rx = d[4];
    repeat (H) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6 rst rx_data", 32'(bus.rx_data), 32'h00);
    check("t6 rst rx_valid", 32'(bus.rx_valid), 32'h0);
    check("t6 rst parity_err", 32'(bus.parity_err), 32'h0);
    check("t6 rst frame_err", 32'(bus.frame_err), 32'h0);
    last_data = 8'h00;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(20);
    compare("t6 abort");
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    idle(10);
    compare("t6");

    // Random frames: data, parity mode, occasional bad parity and bad stop
    for (int k = 0; k < 12; k++) begin
      d     = 8'($urandom);
      pen   = 1'($urandom_range(0, 1));
      pbit  = (^d) ^ ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 4) != 0);
      send_frame(d, pen, pbit, stopb);
      idle(stopb ? 3 : 12);
      compare("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
